// File: rtl/spi_mem_master.sv
// SPI mode-0 master for single-word reads/writes to an external SPI memory.
// Define SPI_PARITY_EN to append an even-parity bit over the data field.
module spi_mem_master #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int NUM_CS    = 2,
  parameter int CLK_DIV   = 2,
  localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              sclk,
  output logic [NUM_CS-1:0] cs_n,
  output logic              mosi,
  input  logic              miso
);

`ifdef SPI_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int N     = 1 + ADDR_W + DATA_W + PAR_W;
  localparam int RX_W  = DATA_W + PAR_W;
  localparam int BIT_W = $clog2(N);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_DONE} state_t;

  state_t              r_state, w_state_nx;
  logic [DIV_W-1:0]    r_div;
  logic [BIT_W-1:0]    r_bit;
  logic                r_sclk, r_mosi, r_wr, r_err;
  logic [NUM_CS-1:0]   r_cs_n;
  logic [N-2:0]        r_shift;
  logic [RX_W-1:0]     r_rx;
  logic [DATA_W-1:0]   r_dout;
  logic [DATA_W-1:0]   w_wdata;
  logic [N-1:0]        w_frame;
  logic                w_req_bad, w_div_end, w_last, w_rx_bad;

  assign w_req_bad = (32'(addr) >= 32'(MEM_DEPTH)) || (32'(cs_sel) >= 32'(NUM_CS));
  assign w_wdata   = wr ? din : '0;
`ifdef SPI_PARITY_EN
  assign w_frame   = {wr, addr, w_wdata, ^w_wdata};
  assign w_rx_bad  = !r_wr && (r_rx[0] != ^r_rx[RX_W-1:1]);
`else
  assign w_frame   = {wr, addr, w_wdata};
  assign w_rx_bad  = 1'b0;
`endif
  assign w_div_end = (r_div == DIV_W'(CLK_DIV - 1));
  // A bit ends at the close of its low phase; the last one ends the frame.
  assign w_last    = w_div_end && !r_sclk && (r_bit == BIT_W'(N - 1));

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (req) w_state_nx = w_req_bad ? S_DONE : S_SETUP;
      S_SETUP: if (w_div_end) w_state_nx = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= '0;
      r_bit  <= '0;
      r_sclk <= 1'b0;
      r_mosi <= 1'b0;
      r_cs_n <= '1;
      r_err  <= 1'b0;
      r_dout <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req) begin
          r_div <= '0;
          r_bit <= '0;
          r_err <= w_req_bad;
          if (!w_req_bad) begin
            r_cs_n <= ~(NUM_CS'(1) << cs_sel);
            r_mosi <= w_frame[N-1];
          end
        end
        S_SETUP: begin
          r_div <= w_div_end ? '0 : r_div + 1'b1;
          if (w_div_end) r_sclk <= 1'b1;
        end
        S_SHIFT: begin
          r_div <= w_div_end ? '0 : r_div + 1'b1;
          if (w_div_end) begin
            r_sclk <= !r_sclk && !w_last;
            if (r_sclk) r_mosi <= r_shift[N-2];
            else        r_bit  <= r_bit + 1'b1;
          end
          if (w_last) begin
            r_cs_n <= '1;
            r_err  <= w_rx_bad;
            if (!r_wr) r_dout <= r_rx[RX_W-1 -: DATA_W];
          end
        end
        default: ;
      endcase
    end
  end

  // Frame/receive shifters carry data only; they are reloaded at every accept.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && req) begin
      r_wr    <= wr;
      r_shift <= w_frame[N-2:0];
    end else if (r_state == S_SHIFT && w_div_end && r_sclk) begin
      r_shift <= r_shift << 1;
    end
    if (r_state == S_SHIFT && r_sclk && r_div == '0)
      r_rx <= RX_W'({r_rx, miso});
  end

  assign dout = r_dout;
  assign done = (r_state == S_DONE);
  assign err  = done && r_err;
  assign busy = (r_state != S_IDLE);
  assign sclk = r_sclk;
  assign cs_n = r_cs_n;
  assign mosi = r_mosi;

endmodule

// File: tb/tb_spi_mem_master.sv
// Directed self-checking bench for spi_mem_master (default instance plus a
// 9-bit-address, single-slave instance for range/select error cases).
module tb_spi_mem_master;

`ifdef SPI_PARITY_EN
  localparam int NF = 18;
  localparam logic [NF-1:0] EXP_WR  = 18'b1_0001_0010_1010_0101_0;
  localparam logic [NF-1:0] EXP_RD  = 18'b0_0001_0010_0000_0000_0;
  localparam logic [NF-1:0] EXP_B2B = 18'b1_0000_0010_0010_0010_0;
  localparam logic [NF-1:0] RX_3C   = 18'b0_0000_0000_0011_1100_0;
`else
  localparam int NF = 17;
  localparam logic [NF-1:0] EXP_WR  = 17'b1_0001_0010_1010_0101;
  localparam logic [NF-1:0] EXP_RD  = 17'b0_0001_0010_0000_0000;
  localparam logic [NF-1:0] EXP_B2B = 17'b1_0000_0010_0010_0010;
  localparam logic [NF-1:0] RX_3C   = 17'b0_0000_0000_0011_1100;
`endif
  localparam int LAT   = (2 * NF + 1) * 2 + 1;
  localparam int LAT_E = (2 * (NF + 1) + 1) * 2 + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       req, wr, miso;
  logic [0:0] cs_sel;
  logic [7:0] addr, din, dout;
  logic       done, err, busy, sclk, mosi;
  logic [1:0] cs_n;

  logic       e_req, e_wr, e_miso;
  logic [0:0] e_cs_sel, e_cs_n;
  logic [8:0] e_addr;
  logic [7:0] e_din, e_dout;
  logic       e_done, e_err, e_busy, e_sclk, e_mosi;

  int n_tests = 0;
  int n_fail  = 0;

  logic [NF-1:0] t_mframe;
  logic [7:0]    t_dout;
  logic [1:0]    t_cs_done;
  int            t_dcyc, t_rise, t_csbad;
  logic          t_err;

  always #5 clk = ~clk;

  spi_mem_master u_dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .cs_sel(cs_sel), .addr(addr),
    .din(din), .dout(dout), .done(done), .err(err), .busy(busy),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  spi_mem_master #(.ADDR_W(9), .MEM_DEPTH(256), .NUM_CS(1)) u_dut_e (
    .clk(clk), .rst(rst), .req(e_req), .wr(e_wr), .cs_sel(e_cs_sel), .addr(e_addr),
    .din(e_din), .dout(e_dout), .done(e_done), .err(e_err), .busy(e_busy),
    .sclk(e_sclk), .cs_n(e_cs_n), .mosi(e_mosi), .miso(e_miso)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transaction on slave 0; acts as a mode-0 slave driving rxf on miso.
  task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic [NF-1:0] rxf);
    int   nr;
    logic ps;
    wr = w; addr = a; din = d; cs_sel = 1'b0; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    t_dcyc = -1; t_mframe = '0; t_csbad = 0; t_err = 1'b0; t_dout = '0; t_cs_done = '0;
    nr = 0; ps = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (sclk && !ps) begin
        t_mframe = {t_mframe[NF-2:0], mosi};
        nr++;
        if (cs_n !== 2'b10) t_csbad++;
      end
      if (!sclk && nr < NF) miso = rxf[NF-1-nr];
      if (done) begin
        t_dcyc = k; t_err = err; t_dout = dout; t_cs_done = cs_n;
        break;
      end
      ps = sclk;
      @(posedge clk); #1;
    end
    t_rise = nr;
    miso = 1'b0;
  endtask

  initial begin
    int d1, d2, bl, extra, ndone;
    logic ps;
    logic [NF-1:0] fr2;

    rst = 1'b1; req = 1'b0; wr = 1'b0; cs_sel = '0; addr = '0; din = '0; miso = 1'b0;
    e_req = 1'b0; e_wr = 1'b0; e_cs_sel = '0; e_addr = '0; e_din = '0; e_miso = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_dout", dout, 8'h00);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_err",  err,  1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_sclk", sclk, 1'b0);
    check_eq("rst_cs_n", cs_n, 2'b11);
    check_eq("rst_mosi", mosi, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write 0xA5 to 0x12
    run_txn(1'b1, 8'h12, 8'hA5, '0);
    check_eq("wr_lat",     t_dcyc, LAT);
    check_eq("wr_err",     t_err, 1'b0);
    check_eq("wr_frame",   t_mframe, EXP_WR);
    check_eq("wr_rises",   t_rise, NF);
    check_eq("wr_csn",     t_csbad, 0);
    check_eq("wr_csn_dn",  t_cs_done, 2'b11);
    check_eq("wr_busy_dn", busy, 1'b1);
    check_eq("wr_dout",    t_dout, 8'h00);
    @(posedge clk); #1;
    check_eq("wr_busy_off", busy, 1'b0);
    check_eq("wr_done_off", done, 1'b0);

    // Read 0x12, slave answers 0x3C
    run_txn(1'b0, 8'h12, 8'hFF, RX_3C);
    check_eq("rd_lat",   t_dcyc, LAT);
    check_eq("rd_err",   t_err, 1'b0);
    check_eq("rd_dout",  t_dout, 8'h3C);
    check_eq("rd_frame", t_mframe, EXP_RD);
    check_eq("rd_csn",   t_csbad, 0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("rd_hold", dout, 8'h3C);

    // req held high across two writes, then toggled during the second
    wr = 1'b1; addr = 8'h01; din = 8'h11; req = 1'b1;
    @(posedge clk); #1;
    addr = 8'h02; din = 8'h22;
    d1 = -1; d2 = -1; bl = -1; extra = 0; ps = 1'b0; fr2 = '0;
    for (int k = 1; k <= 400; k++) begin
      if (done) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) begin d2 = k; req = 1'b0; end
      end
      if (d1 > 0 && bl < 0 && !busy) bl = k;
      if (bl > 0 && sclk && !ps) fr2 = {fr2[NF-2:0], mosi};
      if (bl > 0 && d2 < 0 && busy) req = k[0];
      if (d2 > 0 && k > d2 + 1 && busy) extra++;
      ps = sclk;
      if (d2 > 0 && k >= d2 + 10) break;
      @(posedge clk); #1;
    end
    req = 1'b0;
    check_eq("b2b_done1",  d1, LAT);
    check_eq("b2b_idle",   bl, LAT + 1);
    check_eq("b2b_done2",  d2, 2 * LAT + 1);
    check_eq("b2b_frame2", fr2, EXP_B2B);
    check_eq("b2b_extra",  extra, 0);
    check_eq("b2b_dout",   dout, 8'h3C);

    // Reset in the middle of a write
    wr = 1'b1; addr = 8'h55; din = 8'hFF; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check_eq("mid_busy", busy, 1'b1);
    check_eq("mid_csn",  cs_n, 2'b10);
    #3 rst = 1'b1;
    #1;
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_csn",  cs_n, 2'b11);
    check_eq("arst_sclk", sclk, 1'b0);
    check_eq("arst_mosi", mosi, 1'b0);
    check_eq("arst_dout", dout, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check_eq("arst_nodone", ndone, 0);
    run_txn(1'b1, 8'h03, 8'h5A, '0);
    check_eq("post_rst_lat", t_dcyc, LAT);
    check_eq("post_rst_err", t_err, 1'b0);

    // Range and select errors on the 9-bit, single-slave instance
    e_addr = 9'd300; e_cs_sel = 1'b0; e_req = 1'b1;
    @(posedge clk); #1;
    e_req = 1'b0;
    check_eq("erng_done", e_done, 1'b1);
    check_eq("erng_err",  e_err, 1'b1);
    check_eq("erng_busy", e_busy, 1'b1);
    check_eq("erng_sclk", e_sclk, 1'b0);
    check_eq("erng_csn",  e_cs_n, 1'b1);
    check_eq("erng_dout", e_dout, 8'h00);
    @(posedge clk); #1;
    check_eq("erng_done_off", e_done, 1'b0);
    check_eq("erng_busy_off", e_busy, 1'b0);
    e_addr = 9'd5; e_cs_sel = 1'b1; e_req = 1'b1;
    @(posedge clk); #1;
    e_req = 1'b0;
    check_eq("esel_done", e_done, 1'b1);
    check_eq("esel_err",  e_err, 1'b1);
    check_eq("esel_csn",  e_cs_n, 1'b1);
    @(posedge clk); #1;
    e_addr = 9'd255; e_cs_sel = 1'b0; e_wr = 1'b1; e_din = 8'h81; e_req = 1'b1;
    @(posedge clk); #1;
    e_req = 1'b0;
    check_eq("eok_done_early", e_done, 1'b0);
    d1 = -1;
    for (int k = 1; k <= 400; k++) begin
      if (e_done) begin d1 = k; check_eq("eok_err", e_err, 1'b0); break; end
      @(posedge clk); #1;
    end
    check_eq("eok_lat", d1, LAT_E);

`ifdef SPI_PARITY_EN
    run_txn(1'b0, 8'h20, 8'h00, 18'b0_0000_0000_0000_0111_1);
    check_eq("par_ok_err",  t_err, 1'b0);
    check_eq("par_ok_dout", t_dout, 8'h07);
    check_eq("par_ok_lat",  t_dcyc, LAT);
    @(posedge clk); #1;
    run_txn(1'b0, 8'h20, 8'h00, 18'b0_0000_0000_0000_0111_0);
    check_eq("par_bad_err",  t_err, 1'b1);
    check_eq("par_bad_dout", t_dout, 8'h07);
`else
    run_txn(1'b0, 8'h20, 8'h00, 17'b0_0000_0000_0000_0111);
    check_eq("rd07_err",  t_err, 1'b0);
    check_eq("rd07_dout", t_dout, 8'h07);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
